seq_booth_mul: RTL and testbench

SEQ_BOOTH_MUL -- requirements
Module: seq_booth_mul

---
 rtl/seq_booth_mul_if.sv | 39 +++
 rtl/seq_booth_mul.sv | 147 ++++++++++++++
 tb/tb_seq_booth_mul.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seq_booth_mul_if.sv
// -----------------------------------------------------------------------------
// seq_booth_mul_if
// Request/response bundle between an initiator and the sequential Booth
// multiplier. The clock and reset stay outside the bundle as plain ports.
//
//   enable    : initiator -> multiplier, starts an operation and holds it
//   M, R      : initiator -> multiplier, signed fixed-point operands
//   mulResult : multiplier -> initiator, signed fixed-point product
//   finish    : multiplier -> initiator, mulResult valid for this request
//   busy      : multiplier -> initiator, Booth iteration in progress
// -----------------------------------------------------------------------------
interface seq_booth_mul_if #(
    parameter int N = 16
);
    logic                enable;
    logic signed [N-1:0] M;
    logic signed [N-1:0] R;
    logic signed [N-1:0] mulResult;
    logic                finish;
    logic                busy;

    modport master (
        output enable,
        output M,
        output R,
        input  mulResult,
        input  finish,
        input  busy
    );

    modport slave (
        input  enable,
        input  M,
        input  R,
        output mulResult,
        output finish,
        output busy
    );
endinterface

// File: rtl/seq_booth_mul.sv
// -----------------------------------------------------------------------------
// seq_booth_mul
// Sequential radix-2 Booth multiplier for signed Q(N-FRAC).FRAC operands.
// One Booth step per clock; the product is rescaled by an arithmetic shift
// right of FRAC (floor) and returned as an N-bit fixed-point value.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset
//   bus    : seq_booth_mul_if.slave (enable, M, R, mulResult, finish, busy)
//
// Timing: the edge that samples enable in IDLE captures the operands; N
// Booth steps follow, and finish is first visible N+1 cycles after that edge.
//
// Build option: define SEQ_MUL_SAT_EN to clamp out-of-range products to the
// signed N-bit limits instead of wrapping.
// -----------------------------------------------------------------------------
module seq_booth_mul #(
    parameter int N    = 16,
    parameter int FRAC = 8
) (
    input  logic            clk,
    input  logic            reset,
    seq_booth_mul_if.slave  bus
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic signed [N-1:0] mCap;
    // Accumulator layout: {A[N-1:0], Q[N-1:0], Qm1}
    logic [2*N:0]        acc;
    logic [CW-1:0]       cnt;
    logic signed [N-1:0] mulResult;
    logic                finish;
    logic                busy;

    logic signed [N:0]   aExt;
    logic signed [N:0]   mExt;
    logic signed [N:0]   sum;
    logic [2*N:0]        accNext;
    logic signed [N-1:0] resultFit;

`ifdef SEQ_MUL_SAT_EN
    // top holds product bits [2N-1:N+FRAC-1]; they must all equal the sign
    // bit for the rescaled value to fit in N bits.
    function automatic logic signed [N-1:0] fitResult(
        input logic [N-FRAC:0] top,
        input logic [N-1:0]    mid
    );
        if ((&top) || !(|top))
            return mid;
        else if (top[N-FRAC])
            return {1'b1, {(N-1){1'b0}}};
        else
            return {1'b0, {(N-1){1'b1}}};
    endfunction
`else
    function automatic logic signed [N-1:0] fitResult(
        input logic [N-1:0] mid
    );
        return mid;
    endfunction
`endif

    // The add/subtract is done one bit wider than A so that the most
    // negative multiplicand cannot overflow; the arithmetic shift right then
    // brings the sum back to N bits without losing the sign.
    always_comb begin
        aExt = {acc[2*N], acc[2*N:N+1]};
        mExt = {mCap[N-1], mCap};
        sum  = aExt;
        case (acc[1:0])
            2'b01:   sum = aExt + mExt;
            2'b10:   sum = aExt - mExt;
            default: sum = aExt;
        endcase
        accNext = {sum, acc[N:1]};
    end

    // Product bit i lives at acc[i+1]; select bits [N+FRAC-1:FRAC].
`ifdef SEQ_MUL_SAT_EN
    assign resultFit = fitResult(acc[2*N:N+FRAC], acc[N+FRAC:FRAC+1]);
`else
    assign resultFit = fitResult(acc[N+FRAC:FRAC+1]);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            finish    <= 1'b0;
            busy      <= 1'b0;
            mulResult <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        mCap  <= bus.M;
                        acc   <= {{N{1'b0}}, bus.R, 1'b0};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CW'(N)) begin
                        mulResult <= resultFit;
                        finish    <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        acc <= accNext;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Holding enable keeps the result up; no restart from here.
                    if (!bus.enable) begin
                        finish <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mulResult = mulResult;
    assign bus.finish    = finish;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_seq_booth_mul.sv
// -----------------------------------------------------------------------------
// tb_seq_booth_mul
// Directed bench for seq_booth_mul (N=16, FRAC=8). Expected products come
// from a 64-bit reference multiply, pushed at operation start and popped
// when finish rises. Follows SEQ_MUL_SAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seq_booth_mul;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [15:0] expQ[$];
    logic [15:0] lastRes;

    seq_booth_mul_if #(.N(16)) bus ();

    seq_booth_mul #(.N(16), .FRAC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] m, input logic [15:0] r);
        longint p;
        longint sh;
        p  = longint'($signed(m)) * longint'($signed(r));
        sh = p >>> 8;
`ifdef SEQ_MUL_SAT_EN
        if (sh > 64'sd32767)
            return 16'h7FFF;
        else if (sh < -64'sd32768)
            return 16'h8000;
`endif
        return sh[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive operands with enable; the next edge samples them (cycle 0).
    task automatic startOp(input logic [15:0] m, input logic [15:0] r);
        bus.M      = m;
        bus.R      = r;
        bus.enable = 1'b1;
        expQ.push_back(model(m, r));
        tick();
        check("busy_at_start", {31'd0, bus.busy}, 32'd1);
        check("finish_at_start", {31'd0, bus.finish}, 32'd0);
    endtask

    // Wait (bounded) for finish; check latency, busy window and result.
    task automatic finishOp(input string tag, input logic scramble);
        int lat;
        int busyCnt;
        logic [15:0] exp;
        lat     = 0;
        busyCnt = 0;
        while (bus.finish !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (scramble) begin
                bus.M = 16'($urandom);
                bus.R = 16'($urandom);
            end
            if (bus.finish !== 1'b1 && bus.busy === 1'b1)
                busyCnt++;
        end
        check({tag, "_latency"}, lat, 32'd17);
        check({tag, "_busy_cycles"}, busyCnt, 32'd16);
        check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_queue"}, expQ.size(), 32'd1);
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            check({tag, "_result"}, {16'd0, bus.mulResult}, {16'd0, exp});
            lastRes = exp;
        end
    endtask

    task automatic releaseOp(input string tag);
        bus.enable = 1'b0;
        tick();
        check({tag, "_rel_finish"}, {31'd0, bus.finish}, 32'd0);
        check({tag, "_rel_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_rel_hold"}, {16'd0, bus.mulResult}, {16'd0, lastRes});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        lastRes    = 16'h0000;
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.M      = 16'h1234;
        bus.R      = 16'h0567;
        repeat (3) tick();
        check("rst_finish", {31'd0, bus.finish}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_result", {16'd0, bus.mulResult}, 32'd0);
        bus.enable = 1'b0;
        reset      = 1'b0;
        tick();
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        // 2.0 x 3.0
        startOp(16'h0200, 16'h0300);
        finishOp("two_x_three", 1'b0);
        releaseOp("two_x_three");

        // -1.5 x 2.0, floor of -1 LSB, underflow to zero
        startOp(16'hFE80, 16'h0200);
        finishOp("neg_x_pos", 1'b0);
        releaseOp("neg_x_pos");
        startOp(16'hFFFF, 16'h0001);
        finishOp("floor_neg", 1'b0);
        releaseOp("floor_neg");
        startOp(16'h0001, 16'h0001);
        finishOp("tiny", 1'b0);
        releaseOp("tiny");

        // Most-negative squared and positive overflow
        startOp(16'h8000, 16'h8000);
        finishOp("minsq", 1'b0);
        releaseOp("minsq");
        startOp(16'h7FFF, 16'h0200);
        finishOp("ovf", 1'b0);
        releaseOp("ovf");

        // Abort during RUN: drop enable at cycle 8
        startOp(16'h0100, 16'h0500);
        repeat (8) tick();
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.enable = 1'b0;
        tick();
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_finish", {31'd0, bus.finish}, 32'd0);
        check("abort_hold", {16'd0, bus.mulResult}, {16'd0, lastRes});
        void'(expQ.pop_back());
        repeat (3) begin
            tick();
            check("abort_idle_finish", {31'd0, bus.finish}, 32'd0);
        end
        startOp(16'h0100, 16'h0500);
        finishOp("restart", 1'b0);
        releaseOp("restart");

        // Reset in the completion cycle, then immediate restart
        startOp(16'h0300, 16'h0300);
        repeat (16) tick();
        check("rstc_busy_pre", {31'd0, bus.busy}, 32'd1);
        check("rstc_finish_pre", {31'd0, bus.finish}, 32'd0);
        reset = 1'b1;
        tick();
        check("rstc_finish", {31'd0, bus.finish}, 32'd0);
        check("rstc_result", {16'd0, bus.mulResult}, 32'd0);
        check("rstc_busy", {31'd0, bus.busy}, 32'd0);
        void'(expQ.pop_back());
        lastRes = 16'h0000;
        reset   = 1'b0;
        startOp(16'hFD00, 16'h0280);
        finishOp("after_reset", 1'b0);
        releaseOp("after_reset");

        // Operands scrambled during RUN; enable held after DONE
        startOp(16'h0A40, 16'hF9C0);
        finishOp("scramble", 1'b1);
        repeat (5) begin
            tick();
            check("hold_finish", {31'd0, bus.finish}, 32'd1);
            check("hold_busy", {31'd0, bus.busy}, 32'd0);
            check("hold_result", {16'd0, bus.mulResult}, {16'd0, lastRes});
        end
        releaseOp("scramble");

        // A few random operand pairs
        for (int i = 0; i < 6; i++) begin
            startOp(16'($urandom), 16'($urandom));
            finishOp("random", 1'b0);
            releaseOp("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
